// File: rtl/alu_pkg.sv
// alu_pkg: shared OP encoding and default operand width for the ALU
package alu_pkg;
    localparam int ALU_WIDTH = 32;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ADD/SUB/AND/OR datapath with carry; overflow only when ALU_OVF_EN is defined
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             carry
`ifdef ALU_OVF_EN
    ,
    output logic             overflow
`endif
);
    logic             arith;
    logic             sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    // SUB reuses the adder as a + ~b + 1, so carry means "no borrow"
    always_comb begin
        sub    = op == OP_SUB;
        arith  = (op == OP_ADD) || sub;
        b_eff  = sub ? ~b : b;
        sum    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
        result = (op == OP_AND) ? (a & b) : (op == OP_OR) ? (a | b) : sum[WIDTH-1:0];
        carry  = arith & sum[WIDTH];
    end
`ifdef ALU_OVF_EN
    assign overflow = arith & (a[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
`endif
endmodule

// File: rtl/alu.sv
// alu: one-cycle registered ALU with zero/negative/carry flags; overflow port only when ALU_OVF_EN is defined
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] EntradaA,
    input  logic [WIDTH-1:0] EntradaB,
    input  logic [1:0]       OP,
    input  logic             in_valid,
    output logic [WIDTH-1:0] Saida,
    output logic             out_valid,
    output logic             zero,
    output logic             negative,
    output logic             carry
`ifdef ALU_OVF_EN
    ,
    output logic             overflow
`endif
);
    logic [WIDTH-1:0] res;
    logic             res_carry;
`ifdef ALU_OVF_EN
    logic             res_ovf;
`endif
    alu_core #(.WIDTH(WIDTH)) u_core (
        .a        (EntradaA),
        .b        (EntradaB),
        .op       (OP),
        .result   (res),
`ifdef ALU_OVF_EN
        .overflow (res_ovf),
`endif
        .carry    (res_carry)
    );
    // result and flags only load on valid input; otherwise they hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Saida     <= '0;
            out_valid <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
            carry     <= 1'b0;
`ifdef ALU_OVF_EN
            overflow  <= 1'b0;
`endif
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                Saida    <= res;
                zero     <= res == '0;
                negative <= res[WIDTH-1];
                carry    <= res_carry;
`ifdef ALU_OVF_EN
                overflow <= res_ovf;
`endif
            end
        end
    end
endmodule

// File: tb/tb_alu.sv
// tb_alu: randomized and directed self-checking bench for alu against a behavioural model
module tb_alu;
`ifdef ALU_OVF_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [31:0] r;
        logic        z, n, c, v;
    } vec_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] EntradaA = '0;
    logic [31:0] EntradaB = '0;
    logic [1:0]  OP = '0;
    logic        in_valid = 1'b0;
    logic [31:0] Saida;
    logic        out_valid, zero, negative, carry;
    logic        ovf;
    int          vectors = 0;
    int          miscompares = 0;
    logic [35:0] held = '0;
    always #5 clk = ~clk;
    alu dut (
        .clk       (clk),
        .rst       (rst),
        .EntradaA  (EntradaA),
        .EntradaB  (EntradaB),
        .OP        (OP),
        .in_valid  (in_valid),
        .Saida     (Saida),
        .out_valid (out_valid),
        .zero      (zero),
        .negative  (negative),
`ifdef ALU_OVF_EN
        .overflow  (ovf),
`endif
        .carry     (carry)
    );
`ifndef ALU_OVF_EN
    assign ovf = 1'b0;
`endif
    function automatic logic [36:0] obs();
        return {out_valid, Saida, zero, negative, carry, ovf};
    endfunction
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint s = 0;
        logic [31:0] r;
        logic c = 1'b0;
        logic v = 1'b0;
        case (op)
            2'd0: begin r = 32'(ua + ub); c = (ua + ub) >= 64'h1_0000_0000; s = sa + sb; v = s != longint'($signed(r)); end
            2'd1: begin r = 32'(ua - ub); c = ua >= ub; s = sa - sb; v = s != longint'($signed(r)); end
            2'd2: r = a & b;
            default: r = a | b;
        endcase
        return {r, r == 32'd0, r[31], c, v & OVF};
    endfunction
    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        @(negedge clk);
        in_valid = v;
        EntradaA = a;
        EntradaB = b;
        OP = op;
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset();
        #1;
        vectors++;
        if (obs() !== 37'd0) begin
            miscompares++;
            $display("FAIL reset_state: got %h required 0", obs());
        end
        drive(1'b0, '0, '0, 2'd0);
        rst = 1'b0;
        drive(1'b0, '0, '0, 2'd0);
        vectors++;
        if (obs() !== 37'd0) begin
            miscompares++;
            $display("FAIL idle_after_reset: got %h required 0", obs());
        end
    endtask
    task automatic test_directed();
        vec_t t[10];
        logic [36:0] exp;
        t[0] = '{32'd2001, 32'd4001, 2'd0, 32'd6002, 1'b0, 1'b0, 1'b0, 1'b0};
        t[1] = '{32'd2001, 32'd4001, 2'd1, 32'hFFFFF830, 1'b0, 1'b1, 1'b0, 1'b0};
        t[2] = '{32'd2001, 32'd4001, 2'd2, 32'd1921, 1'b0, 1'b0, 1'b0, 1'b0};
        t[3] = '{32'd2001, 32'd4001, 2'd3, 32'd4081, 1'b0, 1'b0, 1'b0, 1'b0};
        t[4] = '{32'hFFFFFFFF, 32'd1, 2'd0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        t[5] = '{32'hFFFFFFFF, 32'd1, 2'd1, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b1, 1'b0};
        t[6] = '{32'hFFFFFFFF, 32'd1, 2'd2, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        t[7] = '{32'hFFFFFFFF, 32'd1, 2'd3, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0};
        t[8] = '{32'h7FFFFFFF, 32'd1, 2'd0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1};
        t[9] = '{32'h80000000, 32'd1, 2'd1, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, t[i].a, t[i].b, t[i].op);
            exp = {1'b1, t[i].r, t[i].z, t[i].n, t[i].c, t[i].v & OVF};
            held = exp[35:0];
            vectors++;
            if (obs() !== exp) begin
                miscompares++;
                $display("FAIL directed[%0d] a=%h b=%h op=%0d: got %h required %h", i, t[i].a, t[i].b, t[i].op, obs(), exp);
            end
        end
    endtask
    task automatic test_random();
        logic v;
        logic [31:0] a, b;
        logic [1:0] op;
        for (int i = 0; i < 300; i++) begin
            v = $urandom_range(0, 3) != 0;
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? a : 32'($urandom);
            op = 2'($urandom_range(0, 3));
            drive(v, a, b, op);
            if (v) held = model(a, b, op);
            vectors++;
            if (obs() !== {v, held}) begin
                miscompares++;
                $display("FAIL random[%0d] v=%b a=%h b=%h op=%0d: got %h required %h", i, v, a, b, op, obs(), {v, held});
            end
        end
    endtask
    task automatic test_back_to_back();
        logic [31:0] a, b;
        logic [1:0] op;
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = $urandom;
            op = 2'(i);
            drive(1'b1, a, b, op);
            held = model(a, b, op);
            vectors++;
            if (obs() !== {1'b1, held}) begin
                miscompares++;
                $display("FAIL back_to_back[%0d]: got %h required %h", i, obs(), {1'b1, held});
            end
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, $urandom, $urandom, 2'($urandom_range(0, 3)));
            vectors++;
            if (obs() !== {1'b0, held}) begin
                miscompares++;
                $display("FAIL hold[%0d]: got %h required %h", i, obs(), {1'b0, held});
            end
        end
    endtask
    task automatic test_async_reset();
        drive(1'b1, 32'h12345678, 32'h0000FFFF, 2'd3);
        held = model(32'h12345678, 32'h0000FFFF, 2'd3);
        vectors++;
        if (obs() !== {1'b1, held}) begin
            miscompares++;
            $display("FAIL pre_reset_op: got %h required %h", obs(), {1'b1, held});
        end
        @(negedge clk);
        in_valid = 1'b1;
        EntradaA = 32'h7FFFFFFF;
        EntradaB = 32'd1;
        OP = 2'd0;
        #2 rst = 1'b1;
        #1;
        held = '0;
        vectors++;
        if (obs() !== 37'd0) begin
            miscompares++;
            $display("FAIL async_reset: got %h required 0", obs());
        end
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (obs() !== 37'd0) begin
            miscompares++;
            $display("FAIL in_flight_discarded: got %h required 0", obs());
        end
        drive(1'b1, 32'd5, 32'd5, 2'd1);
        held = model(32'd5, 32'd5, 2'd1);
        vectors++;
        if (obs() !== {1'b1, held}) begin
            miscompares++;
            $display("FAIL post_reset_op: got %h required %h", obs(), {1'b1, held});
        end
    endtask
    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits; all widths below are WIDTH unless stated.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: EntradaA  input  WIDTH  operand A, unsigned/two's-complement.
REQ-005 Port: EntradaB  input  WIDTH  operand B.
REQ-006 Port: OP  input  2  operation select.
REQ-007 Port: in_valid  input  1  operands and OP valid this cycle.
REQ-008 Port: Saida  output  WIDTH  registered result.
REQ-009 Port: out_valid  output  1  Saida and flags valid this cycle.
REQ-010 Port: zero  output  1  registered, result equals 0.
REQ-011 Port: negative  output  1  registered, result MSB.
REQ-012 Port: carry  output  1  registered, carry-out of adder (ADD/SUB only, else 0).
REQ-013 Port: overflow  output  1  registered signed overflow (present only with ALU_OVF_EN, see Configuration).

Function
REQ-014 OP encoding SHALL be: 00 ADD (A+B), 01 SUB (A-B), 10 AND (A&B), 11 OR (A|B).
REQ-015 ADD/SUB results SHALL wrap modulo 2^WIDTH; no saturation.
REQ-016 SUB SHALL be computed as A + ~B + 1; carry = carry-out of that sum (1 when A >= B unsigned, i.e. no borrow).
REQ-017 Latency SHALL be exactly one cycle: inputs sampled on rising edge with in_valid=1 appear on Saida/flags after that edge, out_valid=1 for that one cycle.
REQ-018 When in_valid=0 at an edge, out_valid SHALL go 0 and Saida/flags SHALL hold their previous values.
REQ-019 Back-to-back in_valid SHALL yield one result per cycle, no bubbles, no backpressure.
REQ-020 zero and negative SHALL be derived from the result being registered, for all four operations.
REQ-021 carry (and overflow) SHALL be 0 for AND/OR.

Reset
REQ-022 rst high SHALL immediately (asynchronously) force Saida=0, out_valid=0, zero=0, negative=0, carry=0, overflow=0.
REQ-023 An operation in flight when rst asserts SHALL be discarded; first valid result after rst deasserts requires a new in_valid.

Configuration
REQ-024 Macro ALU_OVF_EN defined: overflow port present; overflow=1 for ADD when A,B same sign and result sign differs, for SUB when A,B differ in sign and result sign differs from A.
REQ-025 Macro ALU_OVF_EN undefined: overflow port and its logic absent; all other behaviour identical.

Structure
REQ-026 Shared package alu_pkg SHALL hold the OP encoding constants (OP_ADD, OP_SUB, OP_AND, OP_OR) and the default WIDTH.
REQ-027 Combinational datapath SHALL be a sub-module alu_core (result, carry, overflow); alu adds the output/valid register stage.

Verification
REQ-028 A=2001, B=4001, OP=00 -> Saida=6002, zero=0, negative=0, carry=0, overflow=0, one cycle later.
REQ-029 A=2001, B=4001, OP=01 -> Saida=0xFFFFF830 (-2000), negative=1, carry=0; OP=10 -> 1921; OP=11 -> 4081.
REQ-030 A=0xFFFFFFFF, B=1: OP=00 -> Saida=0, zero=1, carry=1, overflow=0; OP=01 -> 0xFFFFFFFE, carry=1; OP=10 -> 1; OP=11 -> 0xFFFFFFFF.
REQ-031 A=0x7FFFFFFF, B=1, OP=00 -> Saida=0x80000000, overflow=1, negative=1 (ALU_OVF_EN build).
REQ-032 Four back-to-back valid ops then in_valid=0 -> four consecutive out_valid pulses, then Saida held; rst asserted mid-stream -> all outputs 0 without waiting for clk.
